// File: rtl/column_pkg.sv
// Shared types for the buffered column store.
// Register map, STATUS layout and writer states.
package column_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_DATA   = 2'd1,
    ADDR_DROP   = 2'd2,
    ADDR_COLPTR = 2'd3
  } addr_e;

  localparam int ST_PEND  = 0;
  localparam int ST_STALL = 1;
  localparam int ST_DISP  = 2;
  localparam int ST_WR    = 4;
  localparam int ST_STAGE = 6;

  typedef enum logic {
    FILL,
    STALL
  } wfsm_e;

endpackage

// File: rtl/column_bank.sv
// One column buffer: simple dual-port RAM,
// registered read, no reset on contents.
module column_bank #(
  parameter  int DEPTH = 640,
  parameter  int DW    = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/column_store_ctrl.sv
// N-way buffered column store: Avalon writer assembles columns,
// display buffer swaps only at vertical blank.
module column_store_ctrl
  import column_pkg::*;
#(
  parameter  int NUM_COLS = 640,
  parameter  int WORDS    = 4,
  parameter  int NBUF     = 3,
  localparam int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [1:0]            address,
  input  logic [15:0]           writedata,
  output logic [15:0]           readdata,
  input  logic                  vblank_start,
  input  logic                  rd_en,
  input  logic [COL_W-1:0]      rd_col,
  output logic [WORDS*16-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  frame_swapped
);

  localparam int DW    = WORDS * WORD_W;
  localparam int STG_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  wfsm_e             state_q, state_d;
  logic [1:0]        disp_q, disp_d;
  logic [1:0]        wr_q, wr_d;
  logic [1:0]        pend_q, pend_d;
  logic              pendv_q, pendv_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [15:0]       drop_q, drop_d;
  logic [WORD_W-1:0] stg_q [WORDS];
  logic [DW-1:0]     rec;

  logic [15:0]       readdata_q;
  logic [15:0]       rmux;
  logic [15:0]       status;
  logic              rd_valid_q;
  logic              rd_oob_q;
  logic [1:0]        rd_sel_q;
  logic              swapped_q;
  logic [DW-1:0]     bank_q [NBUF];

  addr_e a;
  logic  bus_wr, accept, last_word, commit, swap, abort, rd_inr;

  assign a         = addr_e'(address);
  assign bus_wr    = chipselect & write;
  assign accept    = bus_wr && (a == ADDR_DATA) && (state_q == FILL);
  assign last_word = accept && (stage_q == STG_W'(WORDS - 1));
  assign commit    = last_word && (col_q == COL_W'(NUM_COLS - 1));
  assign swap      = vblank_start && pendv_q;
  assign abort     = bus_wr && (a == ADDR_CTRL) && writedata[0];
  assign rd_inr    = 32'(rd_col) < NUM_COLS;

  always_comb begin
    rec = '0;
    for (int k = 0; k < WORDS; k++) begin
      rec[k*WORD_W +: WORD_W] =
        (k == WORDS - 1) ? writedata : stg_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    pendv_d = pendv_q;
    stage_d = stage_q;
    col_d   = col_q;
    drop_d  = drop_q;
    if (accept) begin
      if (last_word) begin
        stage_d = '0;
        col_d   = col_q + 1'b1;
      end else begin
        stage_d = stage_q + 1'b1;
      end
    end
    if (swap) begin
      disp_d  = pend_q;
      pendv_d = 1'b0;
      if (NBUF == 2) begin
        wr_d    = disp_q;
        state_d = FILL;
      end
    end
    // Swap is resolved first so the third buffer is picked
    // against the post-edge display index.
    if (commit) begin
      col_d   = '0;
      pend_d  = wr_q;
      pendv_d = 1'b1;
      if (NBUF == 2) begin
        state_d = STALL;
      end else begin
        wr_d = 2'd3 - disp_d - wr_q;
        if (pendv_q && !swap && drop_q != 16'hFFFF)
          drop_d = drop_q + 1'b1;
      end
    end
    if (abort) begin
      stage_d = '0;
      col_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      disp_q  <= 2'd0;
      wr_q    <= 2'd1;
      pend_q  <= 2'd0;
      pendv_q <= 1'b0;
      stage_q <= '0;
      col_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      pendv_q <= pendv_d;
      stage_q <= stage_d;
      col_q   <= col_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !last_word) stg_q[stage_q] <= writedata;
  end

  always_comb begin
    status = '0;
    status[ST_PEND]       = pendv_q;
    status[ST_STALL]      = (state_q == STALL);
    status[ST_DISP +: 2]  = disp_q;
    status[ST_WR +: 2]    = wr_q;
    status[ST_STAGE +: 3] = 3'(stage_q);
  end

  always_comb begin
    rmux = '0;
    unique case (a)
      ADDR_CTRL:   rmux = status;
      ADDR_DATA:   rmux = '0;
      ADDR_DROP:   rmux = drop_q;
      ADDR_COLPTR: rmux = 16'(col_q);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_sel_q   <= 2'd0;
      swapped_q  <= 1'b0;
    end else begin
      if (chipselect && read) readdata_q <= rmux;
      rd_valid_q <= rd_en;
      swapped_q  <= swap;
      if (rd_en) begin
        rd_sel_q <= disp_q;
        rd_oob_q <= !rd_inr;
      end
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_bank
    column_bank #(
      .DEPTH (NUM_COLS),
      .DW    (DW)
    ) u_bank (
      .clk   (clk),
      .we    (last_word && (wr_q == 2'(b))),
      .waddr (col_q),
      .wdata (rec),
      .re    (rd_en && rd_inr),
      .raddr (rd_col),
      .rdata (bank_q[b])
    );
  end

  always_comb begin
    rd_data = '0;
    if (rd_valid_q && !rd_oob_q) begin
      for (int b = 0; b < NBUF; b++) begin
        if (rd_sel_q == 2'(b)) rd_data = bank_q[b];
      end
    end
  end

  assign readdata      = readdata_q;
  assign rd_valid      = rd_valid_q;
  assign frame_swapped = swapped_q;

endmodule

// File: tb/tb_column_store_ctrl.sv
// Directed bench: triple-buffer (dut 0) and double-buffer (dut 1)
// column stores driven side by side.
module tb_column_store_ctrl;

  logic        clk;
  logic        reset;
  logic        cs   [2];
  logic        we   [2];
  logic        re   [2];
  logic [1:0]  adr  [2];
  logic [15:0] wd   [2];
  logic [15:0] rdat [2];
  logic        vb   [2];
  logic        rden [2];
  logic [9:0]  rcol [2];
  logic [63:0] rd   [2];
  logic        rv   [2];
  logic        fs   [2];

  int tests;
  int fails;

  column_store_ctrl #(.NUM_COLS(640), .WORDS(4), .NBUF(3)) u_dut3 (
    .clk(clk), .reset(reset), .chipselect(cs[0]), .write(we[0]),
    .read(re[0]), .address(adr[0]), .writedata(wd[0]),
    .readdata(rdat[0]), .vblank_start(vb[0]), .rd_en(rden[0]),
    .rd_col(rcol[0]), .rd_data(rd[0]), .rd_valid(rv[0]),
    .frame_swapped(fs[0])
  );

  column_store_ctrl #(.NUM_COLS(640), .WORDS(4), .NBUF(2)) u_dut2 (
    .clk(clk), .reset(reset), .chipselect(cs[1]), .write(we[1]),
    .read(re[1]), .address(adr[1]), .writedata(wd[1]),
    .readdata(rdat[1]), .vblank_start(vb[1]), .rd_en(rden[1]),
    .rd_col(rcol[1]), .rd_data(rd[1]), .rd_valid(rv[1]),
    .frame_swapped(fs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input int d, input logic [1:0] a,
                        input logic [15:0] v, input logic vbl);
    @(negedge clk);
    cs[d] = 1'b1; we[d] = 1'b1; adr[d] = a; wd[d] = v; vb[d] = vbl;
    @(posedge clk);
    #1;
    cs[d] = 1'b0; we[d] = 1'b0; vb[d] = 1'b0;
  endtask

  task automatic bus_rd(input int d, input logic [1:0] a,
                        output logic [15:0] v);
    @(negedge clk);
    cs[d] = 1'b1; re[d] = 1'b1; adr[d] = a;
    @(posedge clk);
    #1;
    cs[d] = 1'b0; re[d] = 1'b0;
    v = rdat[d];
  endtask

  task automatic fill_words(input int d, input logic [15:0] base,
                            input int start, input int count,
                            input logic vb_last);
    for (int i = 0; i < count; i++) begin
      bus_wr(d, 2'd1, base + 16'(start + i),
             vb_last && (i == count - 1));
    end
  endtask

  task automatic vblank(input int d, output logic f1, output logic f2);
    @(negedge clk);
    vb[d] = 1'b1;
    @(posedge clk);
    #1;
    vb[d] = 1'b0;
    f1 = fs[d];
    @(posedge clk);
    #1;
    f2 = fs[d];
  endtask

  task automatic col_rd(input int d, input logic [9:0] c,
                        output logic [63:0] data, output logic valid);
    @(negedge clk);
    rden[d] = 1'b1; rcol[d] = c;
    @(posedge clk);
    #1;
    rden[d] = 1'b0;
    data = rd[d];
    valid = rv[d];
  endtask

  logic [15:0] r;
  logic [63:0] data;
  logic        v, f1, f2;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 0; we[d] = 0; re[d] = 0; adr[d] = 0; wd[d] = 0;
      vb[d] = 0; rden[d] = 0; rcol[d] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_rd_valid", 64'(rv[0]), 64'd0);
    check("rst_rd_data", rd[0], 64'd0);
    check("rst_swapped", 64'(fs[0]), 64'd0);
    bus_rd(0, 2'd0, r); check("rst_status", 64'(r), 64'h10);
    bus_rd(0, 2'd2, r); check("rst_drop", 64'(r), 64'h0);
    bus_rd(0, 2'd3, r); check("rst_colptr", 64'(r), 64'h0);

    // triple buffer: first frame
    fill_words(0, 16'h0000, 0, 2560, 1'b0);
    bus_rd(0, 2'd0, r); check("t3_status_pend", 64'(r), 64'h21);
    vblank(0, f1, f2);
    check("t3_swap_pulse", 64'(f1), 64'd1);
    check("t3_swap_pulse_end", 64'(f2), 64'd0);
    bus_rd(0, 2'd0, r); check("t3_status_swap", 64'(r), 64'h24);
    col_rd(0, 10'd5, data, v);
    check("t3_col5", data, {16'd23, 16'd22, 16'd21, 16'd20});
    check("t3_col5_valid", 64'(v), 64'd1);
    check("t3_idle_valid", 64'(rv[0]), 64'd1);
    @(posedge clk); #1;
    check("t3_valid_drop", 64'(rv[0]), 64'd0);

    // two frames before vblank: first is dropped
    fill_words(0, 16'h1000, 0, 2560, 1'b0);
    fill_words(0, 16'h2000, 0, 2560, 1'b0);
    bus_rd(0, 2'd2, r); check("t3_drop_cnt", 64'(r), 64'd1);
    bus_rd(0, 2'd0, r); check("t3_status_drop", 64'(r), 64'h25);
    vblank(0, f1, f2);
    check("t3_swap2_pulse", 64'(f1), 64'd1);
    col_rd(0, 10'd5, data, v);
    check("t3_newest_col5", data,
          {16'h2017, 16'h2016, 16'h2015, 16'h2014});
    bus_rd(0, 2'd0, r); check("t3_status_swap2", 64'(r), 64'h20);

    // commit coinciding with vblank
    fill_words(0, 16'h3000, 0, 2560, 1'b1);
    check("t3_same_cycle_nopulse", 64'(fs[0]), 64'd0);
    @(posedge clk); #1;
    check("t3_same_cycle_nopulse2", 64'(fs[0]), 64'd0);
    bus_rd(0, 2'd0, r); check("t3_status_samecyc", 64'(r), 64'h11);
    vblank(0, f1, f2);
    check("t3_late_swap_pulse", 64'(f1), 64'd1);
    col_rd(0, 10'd5, data, v);
    check("t3_late_col5", data,
          {16'h3017, 16'h3016, 16'h3015, 16'h3014});
    bus_rd(0, 2'd0, r); check("t3_status_late", 64'(r), 64'h18);

    // abort mid-column and out-of-range read
    fill_words(0, 16'h5000, 0, 43, 1'b0);
    bus_rd(0, 2'd0, r); check("abort_pre_status", 64'(r), 64'hD8);
    bus_rd(0, 2'd3, r); check("abort_pre_colptr", 64'(r), 64'd10);
    bus_wr(0, 2'd0, 16'h0001, 1'b0);
    bus_rd(0, 2'd0, r); check("abort_status", 64'(r), 64'h18);
    bus_rd(0, 2'd3, r); check("abort_colptr", 64'(r), 64'd0);
    col_rd(0, 10'd700, data, v);
    check("oob_data", data, 64'd0);
    check("oob_valid", 64'(v), 64'd1);

    // double buffer: writer stalls until vblank
    fill_words(1, 16'h0000, 0, 2560, 1'b0);
    fill_words(1, 16'hAAA0, 0, 8, 1'b0);
    bus_rd(1, 2'd0, r); check("t2_status_stall", 64'(r), 64'h13);
    bus_rd(1, 2'd3, r); check("t2_colptr_stall", 64'(r), 64'd0);
    vblank(1, f1, f2);
    check("t2_swap_pulse", 64'(f1), 64'd1);
    bus_rd(1, 2'd0, r); check("t2_status_run", 64'(r), 64'h04);
    col_rd(1, 10'd5, data, v);
    check("t2_col5", data, {16'd23, 16'd22, 16'd21, 16'd20});
    fill_words(1, 16'hB000, 0, 4, 1'b0);
    fill_words(1, 16'h0000, 4, 2556, 1'b0);
    vblank(1, f1, f2);
    check("t2_swap2_pulse", 64'(f1), 64'd1);
    col_rd(1, 10'd0, data, v);
    check("t2_col0_newbuf", data,
          {16'hB003, 16'hB002, 16'hB001, 16'hB000});
    bus_rd(1, 2'd0, r); check("t2_status_back", 64'(r), 64'h10);

    // reset mid-frame
    fill_words(0, 16'h6000, 0, 1200, 1'b0);
    bus_rd(0, 2'd3, r); check("mid_colptr", 64'(r), 64'd300);
    col_rd(0, 10'd5, data, v);
    @(negedge clk);
    rden[0] = 1'b1; rcol[0] = 10'd5;
    reset = 1'b1;
    #1;
    check("mrst_readdata", 64'(rdat[0]), 64'd0);
    check("mrst_rd_data", rd[0], 64'd0);
    check("mrst_rd_valid", 64'(rv[0]), 64'd0);
    check("mrst_swapped", 64'(fs[0]), 64'd0);
    rden[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_rd(0, 2'd0, r); check("mrst_status", 64'(r), 64'h10);
    bus_rd(0, 2'd2, r); check("mrst_drop", 64'(r), 64'd0);
    bus_rd(0, 2'd3, r); check("mrst_colptr", 64'(r), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
